// File: rtl/ifft_pkg.sv
// Shared constants and helpers for the iterative 8-point inverse FFT.
package ifft_pkg;

  // I/O sample width, internal working width, twiddle scale.
  localparam int DW       = 12;
  localparam int IW       = 16;
  localparam int TW_SCALE = 10;

  // Twiddle coefficient width and width of the twiddle product before the divide.
  localparam int TWW = 5;
  localparam int PW  = IW + 5;

  // Inverse twiddles W^k = e^{+j*2*pi*k/8}, scaled by TW_SCALE.
  localparam logic signed [TWW-1:0] WR [0:3] = '{5'sd10, 5'sd7, 5'sd0, -5'sd7};
  localparam logic signed [TWW-1:0] WI [0:3] = '{5'sd0, 5'sd7, 5'sd10, 5'sd7};

  // FSM encoding.
  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_CALC  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Output clamp limits expressed at the working width.
  localparam logic signed [IW-1:0] SAT_MAX = IW'((1 << (DW - 1)) - 1);
  localparam logic signed [IW-1:0] SAT_MIN = ~SAT_MAX;

  // Bit-reversed index for the 8-entry in-place buffer.
  function automatic logic [2:0] bitrev3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

  // Clamp a working-width value into the DW output range.
  function automatic logic [DW-1:0] sat_dw(input logic signed [IW-1:0] v);
    if (v > SAT_MAX) begin
      return SAT_MAX[DW-1:0];
    end else if (v < SAT_MIN) begin
      return SAT_MIN[DW-1:0];
    end else begin
      return v[DW-1:0];
    end
  endfunction

  // Sign-extend an input sample to the working width.
  function automatic logic [IW-1:0] sext_dw(input logic [DW-1:0] v);
    return {{(IW - DW){v[DW-1]}}, v};
  endfunction

endpackage

// File: rtl/ifft_bfly.sv
// Combinational radix-2 DIT butterfly: t = (b*W)/TW_SCALE, a' = a+t, b' = a-t.
// The divide is signed, so each twiddle product truncates toward zero.
module ifft_bfly
  import ifft_pkg::*;
(
  input  logic [IW-1:0]  a_re,
  input  logic [IW-1:0]  a_im,
  input  logic [IW-1:0]  b_re,
  input  logic [IW-1:0]  b_im,
  input  logic [TWW-1:0] wr,
  input  logic [TWW-1:0] wi,
  output logic [IW-1:0]  ya_re,
  output logic [IW-1:0]  ya_im,
  output logic [IW-1:0]  yb_re,
  output logic [IW-1:0]  yb_im
);

  localparam logic signed [PW-1:0] SCALE = PW'(TW_SCALE);

  logic signed [PW-1:0] bre_x;
  logic signed [PW-1:0] bim_x;
  logic signed [PW-1:0] wr_x;
  logic signed [PW-1:0] wi_x;
  logic signed [PW-1:0] pr;
  logic signed [PW-1:0] pi;
  logic signed [PW-1:0] tr;
  logic signed [PW-1:0] ti;
  logic [IW-1:0]        t_re;
  logic [IW-1:0]        t_im;

  // Complex multiply at the wide product width, scale down, then add/subtract.
  always_comb begin
    bre_x = {{(PW - IW){b_re[IW-1]}}, b_re};
    bim_x = {{(PW - IW){b_im[IW-1]}}, b_im};
    wr_x  = {{(PW - TWW){wr[TWW-1]}}, wr};
    wi_x  = {{(PW - TWW){wi[TWW-1]}}, wi};
    pr    = bre_x * wr_x - bim_x * wi_x;
    pi    = bre_x * wi_x + bim_x * wr_x;
    tr    = pr / SCALE;
    ti    = pi / SCALE;
    t_re  = tr[IW-1:0];
    t_im  = ti[IW-1:0];
    ya_re = a_re + t_re;
    ya_im = a_im + t_im;
    yb_re = a_re - t_re;
    yb_im = a_im - t_im;
  end

endmodule

// File: rtl/ifft8_seq.sv
// Iterative 8-point inverse FFT. Bins arrive serially into a bit-reversed
// buffer, 12 in-place butterflies run one per clock, samples leave serially
// as sat(buffer[n] >>> 3).
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high. in_ready and out_valid depend only on the FSM state, never on the
// opposite-side input; out_re/out_im stay stable while out_valid && !out_ready.
module ifft8_seq
  import ifft_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_im,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_re,
  output logic [DW-1:0] out_im,
  output logic          busy
);

  logic [1:0]    state;
  logic [2:0]    in_cnt;
  logic [3:0]    bf_cnt;
  logic [2:0]    out_cnt;

  logic [IW-1:0] mem_re [0:7];
  logic [IW-1:0] mem_im [0:7];

  logic          load_fire;
  logic          calc_step;
  logic          drain_fire;

  logic [1:0]    stage;
  logic [1:0]    pair;
  logic [2:0]    idx_a;
  logic [2:0]    idx_b;
  logic [1:0]    tw_idx;

  logic [IW-1:0] ya_re;
  logic [IW-1:0] ya_im;
  logic [IW-1:0] yb_re;
  logic [IW-1:0] yb_im;

  assign in_ready   = (state == ST_LOAD);
  assign out_valid  = (state == ST_DRAIN);
  assign busy       = (state == ST_CALC) || (state == ST_DRAIN);
  assign load_fire  = in_valid && in_ready;
  assign calc_step  = (state == ST_CALC);
  assign drain_fire = out_valid && out_ready;

  assign stage = bf_cnt[3:2];
  assign pair  = bf_cnt[1:0];

  // Map the butterfly counter to the two buffer slots and the twiddle index.
  always_comb begin
    idx_a  = 3'd0;
    idx_b  = 3'd0;
    tw_idx = 2'd0;
    case (stage)
      2'd0: begin
        idx_a  = {pair, 1'b0};
        idx_b  = {pair, 1'b1};
        tw_idx = 2'd0;
      end
      2'd1: begin
        idx_a  = {pair[1], 1'b0, pair[0]};
        idx_b  = {pair[1], 1'b1, pair[0]};
        tw_idx = {pair[0], 1'b0};
      end
      default: begin
        idx_a  = {1'b0, pair};
        idx_b  = {1'b1, pair};
        tw_idx = pair;
      end
    endcase
  end

  ifft_bfly u_bfly (
    .a_re  (mem_re[idx_a]),
    .a_im  (mem_im[idx_a]),
    .b_re  (mem_re[idx_b]),
    .b_im  (mem_im[idx_b]),
    .wr    (WR[tw_idx]),
    .wi    (WI[tw_idx]),
    .ya_re (ya_re),
    .ya_im (ya_im),
    .yb_re (yb_re),
    .yb_im (yb_im)
  );

  // FSM and counters; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_LOAD;
      in_cnt  <= 3'd0;
      bf_cnt  <= 4'd0;
      out_cnt <= 3'd0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (load_fire) begin
            in_cnt <= in_cnt + 3'd1;
            if (in_cnt == 3'd7) begin
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (bf_cnt == 4'd11) begin
            bf_cnt <= 4'd0;
            state  <= ST_DRAIN;
          end else begin
            bf_cnt <= bf_cnt + 4'd1;
          end
        end
        ST_DRAIN: begin
          if (drain_fire) begin
            out_cnt <= out_cnt + 3'd1;
            if (out_cnt == 3'd7) begin
              state <= ST_LOAD;
            end
          end
        end
        default: begin
          state <= ST_LOAD;
        end
      endcase
    end
  end

  // Buffer writes: bit-reversed load, then in-place butterfly results.
  // The buffer is not cleared on reset; every frame overwrites all 8 slots.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (load_fire) begin
        mem_re[bitrev3(in_cnt)] <= sext_dw(in_re);
        mem_im[bitrev3(in_cnt)] <= sext_dw(in_im);
      end else if (calc_step) begin
        mem_re[idx_a] <= ya_re;
        mem_im[idx_a] <= ya_im;
        mem_re[idx_b] <= yb_re;
        mem_im[idx_b] <= yb_im;
      end
    end
  end

  // Output path: divide by 8 with floor, then clamp; zero outside DRAIN.
  always_comb begin
    out_re = '0;
    out_im = '0;
    if (state == ST_DRAIN) begin
      out_re = sat_dw($signed(mem_re[out_cnt]) >>> 3);
      out_im = sat_dw($signed(mem_im[out_cnt]) >>> 3);
    end
  end

endmodule

// File: tb/tb_ifft8_seq.sv
// Directed bench for ifft8_seq: hand-computed frames, latency, backpressure,
// mid-frame reset and a round trip from a forward spectrum.
module tb_ifft8_seq;
  import ifft_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_re;
  logic [DW-1:0] in_im;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_re;
  logic [DW-1:0] out_im;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [2*DW-1:0] exp_q[$];
  int              bin_re [8];
  int              bin_im [8];
  logic [DW-1:0]   got_re [8];
  logic [DW-1:0]   got_im [8];

  ifft8_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .busy      (busy)
  );

  // Clock and global time limit.
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_re     = '0;
    in_im     = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic clear_bins();
    for (int k = 0; k < 8; k++) begin
      bin_re[k] = 0;
      bin_im[k] = 0;
    end
  endtask

  task automatic push_exp(input int r, input int i);
    exp_q.push_back({DW'(r), DW'(i)});
  endtask

  // Sends bins 0..7; with gaps, an idle cycle precedes every odd bin.
  task automatic send_frame(input bit gaps);
    int b;
    for (int k = 0; k < 8; k++) begin
      if (gaps && (k % 2 == 1)) begin
        in_valid = 1'b0;
        in_re    = DW'(12'h5a5);
        in_im    = DW'(12'ha5a);
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_re    = DW'(bin_re[k]);
      in_im    = DW'(bin_im[k]);
      b = 0;
      while (!in_ready && b < 100) begin
        @(posedge clk);
        #1;
        b++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Collects up to 8 samples; with bp, out_ready alternates 0,1,0,1...
  task automatic drain_frame(input bit bp, output int n_got, output int hold_bad,
                             output int ready_bad, output bit ready_after);
    int            budget;
    bit            tog;
    bit            v;
    logic [DW-1:0] hr;
    logic [DW-1:0] hi;
    n_got     = 0;
    hold_bad  = 0;
    ready_bad = 0;
    budget    = 0;
    tog       = 1'b0;
    while (n_got < 8 && budget < 200) begin
      out_ready = bp ? tog : 1'b1;
      tog       = !tog;
      v         = out_valid;
      hr        = out_re;
      hi        = out_im;
      if (v && in_ready) ready_bad++;
      @(posedge clk);
      #1;
      budget++;
      if (v && out_ready) begin
        got_re[n_got] = hr;
        got_im[n_got] = hi;
        n_got++;
      end else if (v && !out_ready) begin
        if (!out_valid || out_re !== hr || out_im !== hi) hold_bad++;
      end
    end
    ready_after = in_ready;
    out_ready   = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
    checks++;
    if (out_re !== '0 || out_im !== '0) begin
      errors++;
      $display("FAIL reset_out got (%0d,%0d) want (0,0)", $signed(out_re), $signed(out_im));
    end
  endtask

  task automatic test_dc();
    int            lat;
    int            n_got;
    int            hold_bad;
    int            ready_bad;
    bit            ready_after;
    logic [2*DW-1:0] e;
    clear_bins();
    bin_re[0] = 80;
    send_frame(1'b0);
    lat = 1;
    while (!out_valid && lat < 40) begin
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL dc_calc_flags busy %b in_ready %b want 1 0", busy, in_ready);
      end
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat != 13) begin
      errors++;
      $display("FAIL dc_latency got %0d want 13", lat);
    end
    drain_frame(1'b0, n_got, hold_bad, ready_bad, ready_after);
    checks++;
    if (n_got != 8) begin
      errors++;
      $display("FAIL dc_count got %0d want 8", n_got);
    end
    for (int n = 0; n < 8; n++) push_exp(10, 0);
    for (int n = 0; n < 8; n++) begin
      e = exp_q.pop_front();
      checks++;
      if ({got_re[n], got_im[n]} !== e) begin
        errors++;
        $display("FAIL dc_sample n=%0d got (%0d,%0d) want (%0d,%0d)", n, $signed(got_re[n]),
                 $signed(got_im[n]), $signed(e[2*DW-1:DW]), $signed(e[DW-1:0]));
      end
    end
    checks++;
    if (ready_after !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL dc_back_to_load in_ready %b busy %b want 1 0", ready_after, busy);
    end
  endtask

  task automatic test_tone();
    int            n_got;
    int            hold_bad;
    int            ready_bad;
    bit            ready_after;
    int            er [8] = '{10, 7, 0, -7, -10, -7, 0, 7};
    int            ei [8] = '{0, 7, 10, 7, 0, -7, -10, -7};
    logic [2*DW-1:0] e;
    clear_bins();
    bin_re[1] = 80;
    send_frame(1'b0);
    drain_frame(1'b0, n_got, hold_bad, ready_bad, ready_after);
    checks++;
    if (n_got != 8) begin
      errors++;
      $display("FAIL tone_count got %0d want 8", n_got);
    end
    for (int n = 0; n < 8; n++) push_exp(er[n], ei[n]);
    for (int n = 0; n < 8; n++) begin
      e = exp_q.pop_front();
      checks++;
      if ({got_re[n], got_im[n]} !== e) begin
        errors++;
        $display("FAIL tone_sample n=%0d got (%0d,%0d) want (%0d,%0d)", n, $signed(got_re[n]),
                 $signed(got_im[n]), $signed(e[2*DW-1:DW]), $signed(e[DW-1:0]));
      end
    end
  endtask

  // Frame 0: all bins (2047,0). Frame 1: bins aligned on sample 1 so it
  // exceeds the output range. Frame 2: frame 1 negated.
  task automatic test_full_scale();
    int            n_got;
    int            hold_bad;
    int            ready_bad;
    bit            ready_after;
    int            pr [8] = '{2047, 2047, 0, -2047, -2047, -2047, 0, 2047};
    int            pi [8] = '{0, -2047, -2047, -2047, 0, 2047, 2047, 2047};
    logic [2*DW-1:0] e;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 8; k++) begin
        if (f == 0) begin
          bin_re[k] = 2047;
          bin_im[k] = 0;
        end else begin
          bin_re[k] = (f == 1) ? pr[k] : -pr[k];
          bin_im[k] = (f == 1) ? pi[k] : -pi[k];
        end
      end
      send_frame(1'b0);
      drain_frame(1'b0, n_got, hold_bad, ready_bad, ready_after);
      checks++;
      if (n_got != 8) begin
        errors++;
        $display("FAIL full_count f=%0d got %0d want 8", f, n_got);
      end
      for (int n = 0; n < 8; n++) begin
        if (f == 0) push_exp((n == 0) ? 2047 : 0, 0);
        else if (f == 1) push_exp((n == 1) ? 2047 : (n == 5) ? -410 : 0, 0);
        else push_exp((n == 1) ? -2048 : (n == 5) ? 409 : 0, 0);
      end
      for (int n = 0; n < 8; n++) begin
        e = exp_q.pop_front();
        checks++;
        if ({got_re[n], got_im[n]} !== e) begin
          errors++;
          $display("FAIL full_sample f=%0d n=%0d got (%0d,%0d) want (%0d,%0d)", f, n,
                   $signed(got_re[n]), $signed(got_im[n]), $signed(e[2*DW-1:DW]),
                   $signed(e[DW-1:0]));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int            n_got;
    int            hold_bad;
    int            ready_bad;
    bit            ready_after;
    int            er [8] = '{10, 7, 0, -7, -10, -7, 0, 7};
    int            ei [8] = '{0, 7, 10, 7, 0, -7, -10, -7};
    logic [2*DW-1:0] e;
    for (int f = 0; f < 2; f++) begin
      clear_bins();
      if (f == 0) bin_re[0] = 80;
      else bin_re[1] = 80;
      send_frame(1'b1);
      drain_frame(1'b1, n_got, hold_bad, ready_bad, ready_after);
      checks++;
      if (n_got != 8) begin
        errors++;
        $display("FAIL bp_count f=%0d got %0d want 8", f, n_got);
      end
      checks++;
      if (hold_bad != 0) begin
        errors++;
        $display("FAIL bp_hold f=%0d unstable cycles %0d want 0", f, hold_bad);
      end
      for (int n = 0; n < 8; n++) begin
        if (f == 0) push_exp(10, 0);
        else push_exp(er[n], ei[n]);
      end
      for (int n = 0; n < 8; n++) begin
        e = exp_q.pop_front();
        checks++;
        if ({got_re[n], got_im[n]} !== e) begin
          errors++;
          $display("FAIL bp_sample f=%0d n=%0d got (%0d,%0d) want (%0d,%0d)", f, n,
                   $signed(got_re[n]), $signed(got_im[n]), $signed(e[2*DW-1:DW]),
                   $signed(e[DW-1:0]));
        end
      end
    end
  endtask

  task automatic test_reset_mid_calc();
    int            n_got;
    int            hold_bad;
    int            ready_bad;
    bit            ready_after;
    logic [2*DW-1:0] e;
    clear_bins();
    bin_re[1] = 80;
    bin_im[3] = -500;
    send_frame(1'b0);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_flags in_ready %b out_valid %b busy %b want 1 0 0",
               in_ready, out_valid, busy);
    end
    clear_bins();
    bin_re[0] = 80;
    send_frame(1'b0);
    drain_frame(1'b0, n_got, hold_bad, ready_bad, ready_after);
    checks++;
    if (n_got != 8) begin
      errors++;
      $display("FAIL midrst_count got %0d want 8", n_got);
    end
    for (int n = 0; n < 8; n++) push_exp(10, 0);
    for (int n = 0; n < 8; n++) begin
      e = exp_q.pop_front();
      checks++;
      if ({got_re[n], got_im[n]} !== e) begin
        errors++;
        $display("FAIL midrst_sample n=%0d got (%0d,%0d) want (%0d,%0d)", n, $signed(got_re[n]),
                 $signed(got_im[n]), $signed(e[2*DW-1:DW]), $signed(e[DW-1:0]));
      end
    end
  endtask

  // Forward spectrum of {10,5,-10,12,-15,14,0,-9}, rounded to integers.
  task automatic test_round_trip();
    int n_got;
    int hold_bad;
    int ready_bad;
    bit ready_after;
    int d;
    int xr [8] = '{7, 4, 5, 46, -37, 46, 5, 4};
    int xi [8] = '{0, 2, -16, -18, 0, 18, 16, -2};
    int xs [8] = '{10, 5, -10, 12, -15, 14, 0, -9};
    for (int k = 0; k < 8; k++) begin
      bin_re[k] = xr[k];
      bin_im[k] = xi[k];
    end
    send_frame(1'b0);
    // Offered beats during CALC must be ignored.
    in_valid = 1'b1;
    in_re    = DW'(12'h3ff);
    in_im    = DW'(12'hc01);
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL rt_calc_ready cycle %0d got %b want 0", c, in_ready);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain_frame(1'b0, n_got, hold_bad, ready_bad, ready_after);
    checks++;
    if (n_got != 8) begin
      errors++;
      $display("FAIL rt_count got %0d want 8", n_got);
    end
    checks++;
    if (ready_bad != 0) begin
      errors++;
      $display("FAIL rt_drain_ready high cycles %0d want 0", ready_bad);
    end
    for (int n = 0; n < 8; n++) begin
      d = int'($signed(got_re[n])) - xs[n];
      checks++;
      if (d > 2 || d < -2) begin
        errors++;
        $display("FAIL rt_re n=%0d got %0d want %0d +/-2", n, $signed(got_re[n]), xs[n]);
      end
      d = int'($signed(got_im[n]));
      checks++;
      if (d > 2 || d < -2) begin
        errors++;
        $display("FAIL rt_im n=%0d got %0d want 0 +/-2", n, $signed(got_im[n]));
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_dc();
    test_tone();
    test_full_scale();
    test_backpressure();
    test_reset_mid_calc();
    test_round_trip();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
